// File: rtl/and_gate.sv
// Parameterised bitwise AND cell: combinational output plus a valid-qualified
// registered copy with reduction flags and a saturating all-ones match counter.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one,
  output logic [CNT_W-1:0] match_cnt
);

  logic [WIDTH-1:0] prod;
  logic             prod_all;

  always_comb begin
    prod     = a & b;
    prod_all = &prod;
    y        = prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      all_ones  <= 1'b0;
      any_one   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q      <= prod;
        all_ones <= prod_all;
        any_one  <= |prod;
      end
    end
  end

  // Clear wins over a same-edge increment; counter sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (in_valid && prod_all && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: 1-bit and 8-bit cells plus an 8-bit cell
// with a 2-bit counter, all sharing clock, reset and control inputs.
module tb_and_gate;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_cnt = 1'b0;

  logic        y1, y_q1, out_valid1, all_ones1, any_one1;
  logic [15:0] match_cnt1;
  logic [7:0]  y8, y_q8;
  logic        out_valid8, all_ones8, any_one8;
  logic [15:0] match_cnt8;
  logic [7:0]  ys, y_qs;
  logic        out_valids, all_oness, any_ones;
  logic [1:0]  match_cnts;

  and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .y(y1), .y_q(y_q1), .out_valid(out_valid1), .all_ones(all_ones1), .any_one(any_one1),
    .match_cnt(match_cnt1));

  and_gate #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .y(y8), .y_q(y_q8), .out_valid(out_valid8), .all_ones(all_ones8), .any_one(any_one8),
    .match_cnt(match_cnt8));

  and_gate #(.WIDTH(8), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .y(ys), .y_q(y_qs), .out_valid(out_valids), .all_ones(all_oness), .any_one(any_ones),
    .match_cnt(match_cnts));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  yq;
    logic        all8;
    logic        any8;
    logic [15:0] c8;
    logic [1:0]  cs;
    logic        yq1;
    logic [15:0] c1;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state of the registered side, advanced as stimulus is driven.
  logic [7:0]  m_yq = '0;
  logic        m_all = 1'b0, m_any = 1'b0, m_yq1 = 1'b0;
  logic [15:0] m_c8 = '0, m_c1 = '0;
  logic [1:0]  m_cs = '0;

  task automatic model_reset();
    q.delete();
    m_yq = '0; m_all = 1'b0; m_any = 1'b0; m_yq1 = 1'b0;
    m_c8 = '0; m_c1 = '0; m_cs = '0;
  endtask

  task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic v, input logic c);
    exp_t e;
    logic [7:0] p;
    @(posedge clk);
    #1;
    a = av; b = bv; a1 = av[0]; b1 = bv[0]; in_valid = v; clr_cnt = c;
    p = av & bv;
    if (rst_n) begin
      if (c) begin
        m_c8 = '0; m_cs = '0; m_c1 = '0;
      end else if (v) begin
        if (&p && m_c8 != 16'hFFFF) m_c8 = m_c8 + 16'd1;
        if (&p && m_cs != 2'b11) m_cs = m_cs + 2'd1;
        if (p[0] && m_c1 != 16'hFFFF) m_c1 = m_c1 + 16'd1;
      end
      if (v) begin
        m_yq = p; m_all = &p; m_any = |p; m_yq1 = p[0];
        e.yq = m_yq; e.all8 = m_all; e.any8 = m_any; e.c8 = m_c8; e.cs = m_cs;
        e.yq1 = m_yq1; e.c1 = m_c1; e.due = cyc + 1;
        q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due < cyc) begin
      errors++;
      $display("FAIL sb_timeout: result due at cycle %0d never seen (now %0d)", q[0].due, cyc);
      void'(q.pop_front());
    end
    checks++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (out_valid8 !== 1'b1 || out_valids !== 1'b1 || out_valid1 !== 1'b1 ||
          y_q8 !== e.yq || all_ones8 !== e.all8 || any_one8 !== e.any8 ||
          match_cnt8 !== e.c8 || y_qs !== e.yq || match_cnts !== e.cs ||
          y_q1 !== e.yq1 || all_ones1 !== e.yq1 || any_one1 !== e.yq1 || match_cnt1 !== e.c1) begin
        errors++;
        $display("FAIL sb_result cyc %0d: got ov=%b%b%b yq=%h all=%b any=%b c8=%0d cs=%0d yq1=%b a1=%b o1=%b c1=%0d; want yq=%h all=%b any=%b c8=%0d cs=%0d yq1=%b c1=%0d",
                 cyc, out_valid8, out_valids, out_valid1, y_q8, all_ones8, any_one8, match_cnt8,
                 match_cnts, y_q1, all_ones1, any_one1, match_cnt1,
                 e.yq, e.all8, e.any8, e.c8, e.cs, e.yq1, e.c1);
      end
    end else if (out_valid8 !== 1'b0 || out_valids !== 1'b0 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_spurious_valid cyc %0d: got out_valid=%b%b%b want 000",
               cyc, out_valid8, out_valids, out_valid1);
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (y_q8 !== 8'h00 || out_valid8 !== 1'b0 || all_ones8 !== 1'b0 || any_one8 !== 1'b0 ||
        match_cnt8 !== 16'd0 || match_cnts !== 2'd0 || y_q1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got yq=%h ov=%b all=%b any=%b c8=%0d cs=%0d yq1=%b want all zero",
               y_q8, out_valid8, all_ones8, any_one8, match_cnt8, match_cnts, y_q1);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       want [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a1 = tab[i][1]; b1 = tab[i][0];
      #10;
      checks++;
      if (y1 !== want[i]) begin
        errors++;
        $display("FAIL truth_%b: got y=%b want %b", tab[i], y1, want[i]);
      end
    end
  endtask

  task automatic test_single();
    step(8'hF0, 8'h3C, 1'b1, 1'b0);
    #1;
    checks++;
    if (y8 !== 8'h30) begin
      errors++;
      $display("FAIL single_comb: got y=%h want 30", y8);
    end
    step(8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(8'hFF, 8'hFF, 1'b1, 1'b0);
    step(8'h12, 8'h34, 1'b0, 1'b0);
    step(8'h56, 8'h78, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (y_q8 !== 8'hFF || match_cnt8 !== 16'd3 || all_ones8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: got yq=%h cnt=%0d all=%b want yq=ff cnt=3 all=1",
               y_q8, match_cnt8, all_ones8);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) step(8'hFF, 8'hFF, 1'b1, 1'b0);
    step(8'hFF, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (match_cnts !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold: got cnt=%0d want 3", match_cnts);
    end
    step(8'hFF, 8'hFF, 1'b1, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (match_cnts !== 2'd0 || match_cnt8 !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority: got cs=%0d c8=%0d want 0 0", match_cnts, match_cnt8);
    end
    step(8'hFF, 8'hFF, 1'b1, 1'b0);
    step(8'hFF, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_idle();
    logic [7:0] av, bv;
    for (int i = 0; i < 6; i++) begin
      av = 8'($urandom); bv = 8'($urandom);
      step(av, bv, 1'b0, 1'b0);
      #1;
      checks++;
      if (y8 !== (av & bv)) begin
        errors++;
        $display("FAIL idle_comb: got y=%h want %h", y8, av & bv);
      end
      @(negedge clk);
      checks++;
      if (y_q8 !== m_yq || all_ones8 !== m_all || any_one8 !== m_any || match_cnt8 !== m_c8) begin
        errors++;
        $display("FAIL idle_hold: got yq=%h all=%b any=%b cnt=%0d want yq=%h all=%b any=%b cnt=%0d",
                 y_q8, all_ones8, any_one8, match_cnt8, m_yq, m_all, m_any, m_c8);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(8'hFF, 8'hFF, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (y_q8 !== 8'h00 || out_valid8 !== 1'b0 || all_ones8 !== 1'b0 || any_one8 !== 1'b0 ||
        match_cnt8 !== 16'd0 || match_cnts !== 2'd0 || y8 !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got yq=%h ov=%b all=%b any=%b c8=%0d cs=%0d y=%h want 0s and y=ff",
               y_q8, out_valid8, all_ones8, any_one8, match_cnt8, match_cnts, y8);
    end
    a = 8'h0F;
    #1;
    checks++;
    if (y8 !== 8'h0F) begin
      errors++;
      $display("FAIL reset_comb: got y=%h want 0f", y8);
    end
    step(8'hAA, 8'hFF, 1'b1, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h5A, 8'hFF, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_truth_table();
    #3 rst_n = 1'b1;
    clk_en = 1'b1;
    test_single();
    test_back_to_back();
    test_saturate();
    test_idle();
    test_reset_mid();
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
